// File: rtl/cpu_run_ctrl_pkg.sv
// ============================================================================
// run_ctrl_pkg : shared state encoding and default sizing for cpu_run_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_PC_W        = 32;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_RST_CYCLES  = 1;
  localparam int DEF_MAX_CYCLES  = 95;
  localparam int DEF_HALT_STABLE = 4;

endpackage

`default_nettype wire

// File: rtl/cpu_run_ctrl_if.sv
// ============================================================================
// cpu_run_ctrl_if : host/CPU-side signals of the run controller
// Rev 1.0
// ============================================================================
`default_nettype none

interface cpu_run_ctrl_if
  import run_ctrl_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int CNT_W = DEF_CNT_W
);

  logic             start;
  logic [PC_W-1:0]  pc_i;
  logic             retire_i;
  logic             cpu_rst_o;
  logic             running_o;
  logic             done_o;
  logic             timeout_o;
  logic [CNT_W-1:0] cycle_cnt_o;
  logic [CNT_W-1:0] retired_cnt_o;

  modport master (
    output start, pc_i, retire_i,
    input  cpu_rst_o, running_o, done_o, timeout_o, cycle_cnt_o, retired_cnt_o
  );

  modport slave (
    input  start, pc_i, retire_i,
    output cpu_rst_o, running_o, done_o, timeout_o, cycle_cnt_o, retired_cnt_o
  );

endinterface

`default_nettype wire

// File: rtl/cpu_run_ctrl_pc_stable_det.sv
// ============================================================================
// pc_stable_det : flags the HALT_STABLE-th consecutive identical fetch PC
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_stable_det #(
  parameter int PC_W        = 32,
  parameter int HALT_STABLE = 4
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            run,
  input  wire logic            first,
  input  wire logic [PC_W-1:0] pc,
  output logic                 halt
);

  localparam int SW = (HALT_STABLE > 2) ? $clog2(HALT_STABLE) : 1;

  logic [PC_W-1:0] pc_q;
  logic [SW-1:0]   stable;
  logic            same;

  // The first RUN cycle has no valid previous sample to compare against.
  assign same = run && !first && (pc == pc_q);
  assign halt = same && (stable == SW'(HALT_STABLE - 2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= '0;
      stable <= '0;
    end else begin
      if (run) begin
        pc_q <= pc;
      end
      if (!run || !same) begin
        stable <= '0;
      end else if (stable != SW'(HALT_STABLE - 1)) begin
        stable <= stable + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
// ============================================================================
// cpu_run_ctrl : CPU reset sequencing, bounded run, halt/timeout reporting.
// Optional PC self-loop halt detection: RUN_CTRL_HALT_DETECT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module cpu_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int PC_W        = DEF_PC_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int RST_CYCLES  = DEF_RST_CYCLES,
  parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
  parameter int HALT_STABLE = DEF_HALT_STABLE
) (
  input  wire logic    clk,
  input  wire logic    rst,
  cpu_run_ctrl_if.slave bus
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_e           state;
  logic [RW-1:0]    rst_cnt;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] retired_cnt;
  logic             cpu_rst;
  logic             running;
  logic             done;
  logic             timeout;
  logic             run;
  logic             first;
  logic             halt;
  logic             budget_hit;

  assign run        = (state == ST_RUN);
  assign first      = (cycle_cnt == '0);
  assign budget_hit = (cycle_cnt == CNT_W'(MAX_CYCLES - 1));

`ifdef RUN_CTRL_HALT_DETECT_EN
  pc_stable_det #(
    .PC_W        (PC_W),
    .HALT_STABLE (HALT_STABLE)
  ) u_det (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .first (first),
    .pc    (bus.pc_i),
    .halt  (halt)
  );
`else
  localparam int unused_halt_stable = HALT_STABLE;
  logic unused_pc;
  assign unused_pc = ^bus.pc_i;
  assign halt      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      rst_cnt     <= '0;
      cycle_cnt   <= '0;
      retired_cnt <= '0;
      cpu_rst     <= 1'b1;
      running     <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state       <= ST_RESET;
            rst_cnt     <= '0;
            cycle_cnt   <= '0;
            retired_cnt <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
          end
        end
        ST_RESET: begin
          if (rst_cnt == RW'(RST_CYCLES - 1)) begin
            state   <= ST_RUN;
            cpu_rst <= 1'b0;
            running <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          cycle_cnt <= cycle_cnt + 1'b1;
          if (bus.retire_i && (retired_cnt != '1)) begin
            retired_cnt <= retired_cnt + 1'b1;
          end
          // Halt has priority when both events land in the same cycle.
          if (halt || budget_hit) begin
            state   <= ST_DONE;
            cpu_rst <= 1'b1;
            running <= 1'b0;
            done    <= 1'b1;
            timeout <= !halt;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cpu_rst_o     = cpu_rst;
  assign bus.running_o     = running;
  assign bus.done_o        = done;
  assign bus.timeout_o     = timeout;
  assign bus.cycle_cnt_o   = cycle_cnt;
  assign bus.retired_cnt_o = retired_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
// ============================================================================
// tb_cpu_run_ctrl : directed bench, three controllers with different budgets
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cpu_run_ctrl;

`ifdef RUN_CTRL_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        retire = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.PC_W(32), .CNT_W(16)) bus0 ();
  cpu_run_ctrl_if #(.PC_W(32), .CNT_W(16)) bus1 ();
  cpu_run_ctrl_if #(.PC_W(32), .CNT_W(4))  bus2 ();

  assign bus0.start = start;  assign bus0.pc_i = pc;  assign bus0.retire_i = retire;
  assign bus1.start = start;  assign bus1.pc_i = pc;  assign bus1.retire_i = retire;
  assign bus2.start = start;  assign bus2.pc_i = pc;  assign bus2.retire_i = retire;

  cpu_run_ctrl #(.MAX_CYCLES(95)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  cpu_run_ctrl #(.MAX_CYCLES(13)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  cpu_run_ctrl #(.CNT_W(4), .MAX_CYCLES(15)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected end-of-run results for a controller with budget m.
  task automatic expect_end(input string tag, input bit halt_pat, input int m,
                            input logic done, input logic tmo,
                            input logic [31:0] cyc, input logic [31:0] ret);
    int e_cyc;
    int e_ret;
    bit e_tmo;
    if (halt_pat && HALT_EN) begin
      e_cyc = 13;
      e_tmo = 1'b0;
    end else begin
      e_cyc = m;
      e_tmo = 1'b1;
    end
    e_ret = halt_pat ? 0 : ((m < 50) ? m : 50);
    check({tag, "_done"},    done, 32'd1);
    check({tag, "_timeout"}, tmo,  32'(e_tmo));
    check({tag, "_cycles"},  cyc,  32'(e_cyc));
    check({tag, "_retired"}, ret,  32'(e_ret));
  endtask

  task automatic run_case(input string tag, input bit halt_pat, input bit start_mid);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_reset_cpu_rst"}, bus0.cpu_rst_o,   32'd1);
    check({tag, "_reset_running"}, bus0.running_o,   32'd0);
    check({tag, "_reset_done"},    bus0.done_o,      32'd0);
    check({tag, "_reset_cycles"},  bus0.cycle_cnt_o, 32'd0);
    check({tag, "_reset_retired"}, bus0.retired_cnt_o, 32'd0);
    tick();
    check({tag, "_run1_cpu_rst"}, bus0.cpu_rst_o,   32'd0);
    check({tag, "_run1_running"}, bus0.running_o,   32'd1);
    check({tag, "_run1_cycles"},  bus0.cycle_cnt_o, 32'd0);
    for (int j = 1; j <= 100; j++) begin
      pc     = (halt_pat && j >= 10) ? 32'h40 : 32'h100 + 32'(4 * j);
      retire = !halt_pat && (j <= 50);
      start  = start_mid && (j == 5);
      tick();
      if (!halt_pat && j == 94) begin
        check({tag, "_pre_timeout_done"},   bus0.done_o,      32'd0);
        check({tag, "_pre_timeout_cycles"}, bus0.cycle_cnt_o, 32'd94);
      end
      if (!halt_pat && j == 95) begin
        check({tag, "_timeout_cpu_rst"}, bus0.cpu_rst_o, 32'd1);
        check({tag, "_timeout_running"}, bus0.running_o, 32'd0);
      end
    end
    pc     = 32'h0;
    retire = 1'b0;
    start  = 1'b0;
    expect_end({tag, "_d0"}, halt_pat, 95, bus0.done_o, bus0.timeout_o,
               32'(bus0.cycle_cnt_o), 32'(bus0.retired_cnt_o));
    expect_end({tag, "_d1"}, halt_pat, 13, bus1.done_o, bus1.timeout_o,
               32'(bus1.cycle_cnt_o), 32'(bus1.retired_cnt_o));
    expect_end({tag, "_d2"}, halt_pat, 15, bus2.done_o, bus2.timeout_o,
               32'(bus2.cycle_cnt_o), 32'(bus2.retired_cnt_o));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("por_cpu_rst", bus0.cpu_rst_o,     32'd1);
    check("por_running", bus0.running_o,     32'd0);
    check("por_done",    bus0.done_o,        32'd0);
    check("por_timeout", bus0.timeout_o,     32'd0);
    check("por_cycles",  bus0.cycle_cnt_o,   32'd0);
    check("por_retired", bus0.retired_cnt_o, 32'd0);
    rst = 1'b0;
    tick();
    tick();
    check("idle_cpu_rst", bus0.cpu_rst_o, 32'd1);
    check("idle_running", bus0.running_o, 32'd0);

    run_case("tmo", 1'b0, 1'b1);
    run_case("halt", 1'b1, 1'b0);

    // Asynchronous reset partway through the 30th RUN cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int j = 1; j <= 29; j++) begin
      pc = 32'h100 + 32'(4 * j);
      tick();
    end
    check("mid_running", bus0.running_o,   32'd1);
    check("mid_cycles",  bus0.cycle_cnt_o, 32'd29);
    #2;
    rst = 1'b1;
    #1;
    check("arst_cpu_rst", bus0.cpu_rst_o,   32'd1);
    check("arst_running", bus0.running_o,   32'd0);
    check("arst_done",    bus0.done_o,      32'd0);
    check("arst_cycles",  bus0.cycle_cnt_o, 32'd0);
    tick();
    rst = 1'b0;
    pc  = 32'h0;
    tick();

    run_case("restart", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
